// File: rtl/fetch_inst_queue.sv
// fetch_inst_queue: FIFO between fetch and the format decoder with a registered output stage.
// Accepted pushes are tagged with a wrapping major-ID counter.
module fetch_inst_queue #(
   parameter int addressWidth            = 64,
   parameter int instructionWidth        = 32,
   parameter int PidSize                 = 20,
   parameter int TidSize                 = 16,
   parameter int instructionCounterWidth = 64,
   parameter int queueDepth              = 4
) (
   input  logic                               clock_i,
   input  logic                               reset_i,
   input  logic                               flush_i,
   input  logic                               fetchValid_i,
   input  logic [instructionWidth-1:0]        instruction_i,
   input  logic [addressWidth-1:0]            instructionAddress_i,
   input  logic [PidSize-1:0]                 instructionPid_i,
   input  logic [TidSize-1:0]                 instructionTid_i,
   output logic                               fetchStall_o,
   input  logic                               stall_i,
   output logic                               outputEnable_o,
   output logic [instructionWidth-1:0]        instruction_o,
   output logic [addressWidth-1:0]            instructionAddress_o,
   output logic [PidSize-1:0]                 instructionPid_o,
   output logic [TidSize-1:0]                 instructionTid_o,
   output logic [instructionCounterWidth-1:0] instructionMajId_o
);
   localparam int PW = $clog2(queueDepth);
   typedef struct packed {
      logic [instructionWidth-1:0]        instr;
      logic [addressWidth-1:0]            addr;
      logic [PidSize-1:0]                 pid;
      logic [TidSize-1:0]                 tid;
      logic [instructionCounterWidth-1:0] maj_id;
   } entry_t;
   entry_t mem_q [queueDepth];
   entry_t mem_d [queueDepth];
   entry_t out_q, out_d;
   logic [PW-1:0] head_q, head_d, tail_q, tail_d;
   logic [PW:0] count_q, count_d;
   logic [instructionCounterWidth-1:0] maj_cnt_q, maj_cnt_d;
   logic oe_q, oe_d, full, push, pop;
   assign full = count_q == (PW+1)'(queueDepth);
   // A full queue refuses the push even when a pop frees a slot at the same edge.
   assign push = fetchValid_i & ~full & ~flush_i;
   assign pop  = ~stall_i & ~flush_i & (count_q != '0);
   always_comb begin
      mem_d = mem_q;
      out_d = out_q;
      if (push) mem_d[tail_q] = {instruction_i, instructionAddress_i, instructionPid_i, instructionTid_i, maj_cnt_q};
      if (pop) out_d = mem_q[head_q];
      oe_d      = flush_i ? 1'b0 : stall_i ? oe_q : pop;
      head_d    = flush_i ? '0 : head_q + PW'(pop);
      tail_d    = flush_i ? '0 : tail_q + PW'(push);
      count_d   = flush_i ? '0 : count_q + (PW+1)'(push) - (PW+1)'(pop);
      maj_cnt_d = maj_cnt_q + instructionCounterWidth'(push);
   end
   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         mem_q     <= '{default: '0};
         out_q     <= '0;
         oe_q      <= 1'b0;
         head_q    <= '0;
         tail_q    <= '0;
         count_q   <= '0;
         maj_cnt_q <= '0;
      end else begin
         mem_q     <= mem_d;
         out_q     <= out_d;
         oe_q      <= oe_d;
         head_q    <= head_d;
         tail_q    <= tail_d;
         count_q   <= count_d;
         maj_cnt_q <= maj_cnt_d;
      end
   end
   assign fetchStall_o         = full;
   assign outputEnable_o       = oe_q;
   assign instruction_o        = out_q.instr;
   assign instructionAddress_o = out_q.addr;
   assign instructionPid_o     = out_q.pid;
   assign instructionTid_o     = out_q.tid;
   assign instructionMajId_o   = out_q.maj_id;
endmodule

// File: tb/tb_fetch_inst_queue.sv
// tb_fetch_inst_queue: directed scenario tasks for fetch_inst_queue.
module tb_fetch_inst_queue;
   logic clk = 1'b0, rst = 1'b1, flush = 1'b0, fv = 1'b0, stall = 1'b0;
   logic [31:0] ins = '0;
   logic [63:0] addr = '0;
   logic [19:0] pid = '0;
   logic [15:0] tid = '0;
   logic fstall, oe;
   logic [31:0] ins_o;
   logic [63:0] addr_o, maj_o;
   logic [19:0] pid_o;
   logic [15:0] tid_o;
   int tests = 0, fails = 0;

   fetch_inst_queue dut (
      .clock_i(clk), .reset_i(rst), .flush_i(flush), .fetchValid_i(fv),
      .instruction_i(ins), .instructionAddress_i(addr), .instructionPid_i(pid),
      .instructionTid_i(tid), .fetchStall_o(fstall), .stall_i(stall),
      .outputEnable_o(oe), .instruction_o(ins_o), .instructionAddress_o(addr_o),
      .instructionPid_o(pid_o), .instructionTid_o(tid_o), .instructionMajId_o(maj_o)
   );

   always #5 clk = ~clk;

   task automatic cyc(input logic v, input logic [31:0] in, input logic st, input logic fl);
      fv = v; ins = in; stall = st; flush = fl;
      addr = 64'hFFFF_0000_0000_0000 | {32'h0, in};
      pid = in[19:0] ^ 20'hABCDE;
      tid = 16'h0077;
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      fv = 0; stall = 0; flush = 0; rst = 1;
      @(posedge clk); #1;
      rst = 0;
   endtask

   task automatic test_reset();
      #2;
      tests++; if (oe !== 1'b0) begin fails++; $display("FAIL reset_oe: got %0b want 0", oe); end
      tests++; if (fstall !== 1'b0) begin fails++; $display("FAIL reset_fstall: got %0b want 0", fstall); end
      tests++; if (ins_o !== 32'h0 || maj_o !== 64'h0 || addr_o !== 64'h0) begin fails++; $display("FAIL reset_payload: ins %0h maj %0h addr %0h want 0", ins_o, maj_o, addr_o); end
      cyc(1, 32'h11, 0, 0);
      tests++; if (oe !== 1'b0 || fstall !== 1'b0) begin fails++; $display("FAIL reset_held: oe %0b fstall %0b want 0 0", oe, fstall); end
   endtask

   task automatic test_basic();
      do_reset();
      cyc(1, 32'hA, 0, 0);
      tests++; if (oe !== 1'b0) begin fails++; $display("FAIL basic_nobypass: oe %0b want 0", oe); end
      cyc(0, 0, 0, 0);
      tests++; if (oe !== 1'b1 || ins_o !== 32'hA || maj_o !== 64'd0) begin fails++; $display("FAIL basic_out: oe %0b ins %0h maj %0h want 1 a 0", oe, ins_o, maj_o); end
      tests++; if (addr_o !== 64'hFFFF_0000_0000_000A || pid_o !== 20'hABCD4 || tid_o !== 16'h0077) begin fails++; $display("FAIL basic_meta: addr %0h pid %0h tid %0h", addr_o, pid_o, tid_o); end
      cyc(0, 0, 0, 0);
      tests++; if (oe !== 1'b0) begin fails++; $display("FAIL basic_drain: oe %0b want 0", oe); end
   endtask

   task automatic test_fill();
      do_reset();
      for (int k = 0; k < 4; k++) begin
         cyc(1, 32'h100 + k, 1, 0);
         tests++; if (fstall !== (k == 3)) begin fails++; $display("FAIL fill_stall%0d: got %0b want %0b", k, fstall, k == 3); end
      end
      cyc(1, 32'hBAD, 1, 0);
      tests++; if (fstall !== 1'b1 || oe !== 1'b0) begin fails++; $display("FAIL fill_fifth: fstall %0b oe %0b want 1 0", fstall, oe); end
      for (int k = 0; k < 4; k++) begin
         cyc(0, 0, 0, 0);
         tests++; if (oe !== 1'b1 || maj_o !== 64'(k) || ins_o !== 32'h100 + k) begin fails++; $display("FAIL fill_pop%0d: oe %0b maj %0h ins %0h", k, oe, maj_o, ins_o); end
      end
      cyc(1, 32'h105, 0, 0);
      tests++; if (oe !== 1'b0) begin fails++; $display("FAIL fill_empty: oe %0b want 0", oe); end
      cyc(0, 0, 0, 0);
      tests++; if (oe !== 1'b1 || maj_o !== 64'd4 || ins_o !== 32'h105) begin fails++; $display("FAIL fill_next: oe %0b maj %0h ins %0h want 1 4 105", oe, maj_o, ins_o); end
   endtask

   task automatic test_full_pop();
      do_reset();
      for (int k = 0; k < 4; k++) cyc(1, 32'h200 + k, 1, 0);
      cyc(1, 32'hBAD, 0, 0);
      tests++; if (fstall !== 1'b0 || oe !== 1'b1 || maj_o !== 64'd0 || ins_o !== 32'h200) begin fails++; $display("FAIL fullpop_edge: fstall %0b oe %0b maj %0h ins %0h", fstall, oe, maj_o, ins_o); end
      for (int k = 1; k < 4; k++) begin
         cyc(0, 0, 0, 0);
         tests++; if (oe !== 1'b1 || maj_o !== 64'(k) || ins_o !== 32'h200 + k) begin fails++; $display("FAIL fullpop_pop%0d: oe %0b maj %0h ins %0h", k, oe, maj_o, ins_o); end
      end
      cyc(1, 32'h210, 0, 0);
      tests++; if (oe !== 1'b0) begin fails++; $display("FAIL fullpop_empty: oe %0b want 0", oe); end
      cyc(0, 0, 0, 0);
      tests++; if (oe !== 1'b1 || maj_o !== 64'd4 || ins_o !== 32'h210) begin fails++; $display("FAIL fullpop_next: oe %0b maj %0h ins %0h want 1 4 210", oe, maj_o, ins_o); end
   endtask

   task automatic test_flush();
      do_reset();
      cyc(1, 32'h300, 0, 0);
      cyc(1, 32'h301, 0, 0);
      tests++; if (oe !== 1'b1 || ins_o !== 32'h300) begin fails++; $display("FAIL flush_pre: oe %0b ins %0h want 1 300", oe, ins_o); end
      cyc(1, 32'h302, 1, 0);
      cyc(1, 32'h303, 1, 0);
      tests++; if (oe !== 1'b1 || fstall !== 1'b0 || ins_o !== 32'h300) begin fails++; $display("FAIL flush_hold: oe %0b fstall %0b ins %0h", oe, fstall, ins_o); end
      cyc(1, 32'hBAD, 0, 1);
      tests++; if (oe !== 1'b0 || fstall !== 1'b0) begin fails++; $display("FAIL flush_edge: oe %0b fstall %0b want 0 0", oe, fstall); end
      cyc(0, 0, 0, 0);
      tests++; if (oe !== 1'b0) begin fails++; $display("FAIL flush_stale: oe %0b want 0", oe); end
      cyc(1, 32'h310, 0, 0);
      cyc(0, 0, 0, 0);
      tests++; if (oe !== 1'b1 || maj_o !== 64'd4 || ins_o !== 32'h310) begin fails++; $display("FAIL flush_next: oe %0b maj %0h ins %0h want 1 4 310", oe, maj_o, ins_o); end
   endtask

   task automatic test_wrap();
      do_reset();
      force dut.maj_cnt_q = '1;
      #1 release dut.maj_cnt_q;
      cyc(1, 32'h400, 1, 0);
      cyc(1, 32'h401, 1, 0);
      cyc(0, 0, 0, 0);
      tests++; if (oe !== 1'b1 || maj_o !== 64'hFFFF_FFFF_FFFF_FFFF || ins_o !== 32'h400) begin fails++; $display("FAIL wrap_max: oe %0b maj %0h ins %0h", oe, maj_o, ins_o); end
      cyc(0, 0, 0, 0);
      tests++; if (oe !== 1'b1 || maj_o !== 64'd0 || ins_o !== 32'h401) begin fails++; $display("FAIL wrap_zero: oe %0b maj %0h ins %0h", oe, maj_o, ins_o); end
      do_reset();
      for (int k = 0; k < 10; k++) begin
         cyc(1, 32'h500 + k, 0, 0);
         if (k > 0) begin
            tests++; if (oe !== 1'b1 || maj_o !== 64'(k - 1) || ins_o !== 32'h500 + k - 1) begin fails++; $display("FAIL ptrwrap%0d: oe %0b maj %0h ins %0h", k, oe, maj_o, ins_o); end
         end
      end
      cyc(0, 0, 0, 0);
      tests++; if (oe !== 1'b1 || maj_o !== 64'd9 || ins_o !== 32'h509) begin fails++; $display("FAIL ptrwrap_last: oe %0b maj %0h ins %0h", oe, maj_o, ins_o); end
      cyc(0, 0, 0, 0);
      tests++; if (oe !== 1'b0) begin fails++; $display("FAIL ptrwrap_empty: oe %0b want 0", oe); end
   endtask

   task automatic test_async_reset();
      do_reset();
      cyc(1, 32'h600, 0, 0);
      cyc(1, 32'h601, 0, 0);
      cyc(1, 32'h602, 1, 0);
      tests++; if (oe !== 1'b1 || ins_o !== 32'h600) begin fails++; $display("FAIL arst_pre: oe %0b ins %0h want 1 600", oe, ins_o); end
      #3 rst = 1;
      #1;
      tests++; if (oe !== 1'b0 || fstall !== 1'b0 || ins_o !== 32'h0 || maj_o !== 64'h0) begin fails++; $display("FAIL arst_now: oe %0b fstall %0b ins %0h maj %0h", oe, fstall, ins_o, maj_o); end
      @(posedge clk); #1;
      rst = 0;
      cyc(0, 0, 0, 0);
      tests++; if (oe !== 1'b0) begin fails++; $display("FAIL arst_stale1: oe %0b want 0", oe); end
      cyc(0, 0, 0, 0);
      tests++; if (oe !== 1'b0) begin fails++; $display("FAIL arst_stale2: oe %0b want 0", oe); end
      cyc(1, 32'h610, 0, 0);
      cyc(0, 0, 0, 0);
      tests++; if (oe !== 1'b1 || maj_o !== 64'd0 || ins_o !== 32'h610) begin fails++; $display("FAIL arst_first: oe %0b maj %0h ins %0h want 1 0 610", oe, maj_o, ins_o); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_fill();
      test_full_pop();
      test_flush();
      test_wrap();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
